// File: rtl/i2c_arb_pkg.sv
// Shared types for the i2c_arbiter slice: FSM state encoding, the response
// status codes returned to requesters, and the status field width.
package i2c_arb_pkg;

  localparam int ST_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [ST_W-1:0] {
    ST_OK      = 2'b00,
    ST_NACK    = 2'b01,
    ST_NOSTART = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Bundle of requester-side and i2c_master-side signals of i2c_arbiter.
//   master modport: arbiter view (takes requests and master status,
//                   drives grants, responses and master commands).
//   slave modport : requesters + i2c_master view (the opposite directions).
// Requester i uses req_addr[7i+6:7i] and req_data[8i+7:8i].
interface i2c_arbiter_if
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*7-1:0] req_addr;
  logic [N_REQ-1:0]   req_rw;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [7:0]         rsp_data;
  logic [ST_W-1:0]    rsp_status;
  logic [6:0]         m_addr;
  logic               m_rw;
  logic [7:0]         m_data_w;
  logic               m_start;
  logic [7:0]         m_data_out;
  logic               m_valid_out;
  logic               m_busy;
  logic               m_erro_addr;

  modport master (
    input  req_valid, req_addr, req_rw, req_data,
    input  m_data_out, m_valid_out, m_busy, m_erro_addr,
    output req_ready, rsp_valid, rsp_data, rsp_status,
    output m_addr, m_rw, m_data_w, m_start
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_data,
    output m_data_out, m_valid_out, m_busy, m_erro_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_status,
    input  m_addr, m_rw, m_data_w, m_start
  );
endinterface

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker.
//   req       : request vector
//   last      : index granted most recently
//   grant_idx : first set request searching upward from last+1 (mod N_REQ)
//   any       : at least one request is set
module i2c_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    grant_idx,
  output logic             any
);

  always_comb begin
    int unsigned j;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      // Wrap by subtraction: N_REQ need not be a power of two.
      j = int'(last) + off;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[IW'(j)]) begin
        grant_idx = IW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter and single-byte transaction sequencer in front of
// i2c_master. Grants one requester at a time, drives the master command,
// tracks busy to completion and returns read data plus a status code.
// Start-handshake and busy watchdogs keep a hung bus from locking out others.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester handshake and i2c_master signals (master modport)
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int START_WAIT  = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  i2c_arbiter_if.master bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(START_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, r_last, w_pick;
  logic            w_any;
  logic [6:0]      r_addr;
  logic            r_rw;
  logic [7:0]      r_data_w;
  logic [7:0]      r_rdata;
  logic [WW-1:0]   r_wait_cnt;
  logic [TW-1:0]   r_run_cnt;
  logic            r_nack;
  status_e         r_status, w_status_nxt;
  logic            w_set_status;

  i2c_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req       (bus.req_valid),
    .last      (r_last),
    .grant_idx (w_pick),
    .any       (w_any)
  );

  assign bus.m_addr   = r_addr;
  assign bus.m_rw     = r_rw;
  assign bus.m_data_w = r_data_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_set_status   = 1'b0;
    w_status_nxt   = ST_OK;
    bus.req_ready  = '0;
    bus.rsp_valid  = '0;
    bus.rsp_data   = '0;
    bus.rsp_status = '0;
    bus.m_start    = 1'b0;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = ISSUE;
      ISSUE: begin
        bus.m_start = 1'b1;
        // Wait counter is zero only in the first ISSUE cycle.
        if (r_wait_cnt == '0) bus.req_ready[r_idx] = 1'b1;
        if (bus.m_busy) begin
          w_state_nxt = RUN;
        end else if (r_wait_cnt == WW'(START_WAIT)) begin
          w_set_status = 1'b1;
          w_status_nxt = ST_NOSTART;
          w_state_nxt  = RESP;
        end
      end
      RUN: begin
        // Busy falling is checked first so it wins over watchdog expiry.
        if (!bus.m_busy) begin
          w_set_status = 1'b1;
          w_status_nxt = (r_nack || bus.m_erro_addr) ? ST_NACK : ST_OK;
          w_state_nxt  = RESP;
        end else if (r_run_cnt == TW'(TIMEOUT_CYC)) begin
          w_set_status = 1'b1;
          w_status_nxt = ST_TIMEOUT;
          w_state_nxt  = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid[r_idx] = 1'b1;
        bus.rsp_data         = (r_status == ST_OK) ? r_rdata : '0;
        bus.rsp_status       = r_status;
        w_state_nxt          = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_last     <= IW'(N_REQ - 1);
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_data_w   <= '0;
      r_rdata    <= '0;
      r_wait_cnt <= '0;
      r_run_cnt  <= '0;
      r_nack     <= 1'b0;
      r_status   <= ST_OK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx    <= w_pick;
            r_last   <= w_pick;
            r_addr   <= bus.req_addr[int'(w_pick)*7 +: 7];
            r_rw     <= bus.req_rw[w_pick];
            r_data_w <= bus.req_data[int'(w_pick)*8 +: 8];
            r_rdata  <= '0;
          end
        end
        ISSUE: begin
          if (r_wait_cnt != WW'(START_WAIT)) r_wait_cnt <= r_wait_cnt + WW'(1);
        end
        RUN: begin
          if (r_run_cnt != TW'(TIMEOUT_CYC)) r_run_cnt <= r_run_cnt + TW'(1);
          if (bus.m_erro_addr) r_nack <= 1'b1;
          // Data arriving with an address error is discarded.
          if (bus.m_valid_out && r_rw && !bus.m_erro_addr) r_rdata <= bus.m_data_out;
        end
        RESP: begin
          r_wait_cnt <= '0;
          r_run_cnt  <= '0;
          r_nack     <= 1'b0;
        end
        default: ;
      endcase
      if (w_set_status) r_status <= w_status_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;
  import i2c_arb_pkg::*;

  localparam int NR = 4;
  localparam int SW = 8;
  localparam int TO = 100;
  localparam int M_ACK = 0, M_NACK = 1, M_NOSTART = 2, M_STUCK = 3;

  typedef struct {
    logic [3:0] mask;
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    int         mode;
    logic [7:0] sdata;
    logic [1:0] exp_st;
    logic [7:0] exp_data;
    int         exp_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_arbiter_if #(.N_REQ(NR)) bus();

  i2c_arbiter #(.N_REQ(NR), .START_WAIT(SW), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;
  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_rw      = '0;
    bus.req_data    = '0;
    bus.m_data_out  = '0;
    bus.m_valid_out = 1'b0;
    bus.m_busy      = 1'b0;
    bus.m_erro_addr = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.m_start, bus.m_rw}), 32'(0));
    chk({tag, "_dat"}, 32'({bus.rsp_data, bus.m_addr, bus.m_data_w}), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk_outputs_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_txn(input vec_t v);
    int   rc;
    int   extra;
    logic got;
    for (int r = 0; r < NR; r++) begin
      bus.req_addr[r*7 +: 7] = (r == v.idx) ? v.addr  : 7'(8'h20 + r);
      bus.req_data[r*8 +: 8] = (r == v.idx) ? v.wdata : 8'(8'h30 + r);
      bus.req_rw[r]          = (r == v.idx) ? v.rw    : 1'b0;
    end
    bus.req_valid = v.mask;
    got = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (bus.req_ready != '0) begin
        got = 1'b1;
        chk("grant_lat", 32'(k), 32'(1));
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL grant_wait: got=none want=req_ready[%0d]", v.idx);
      clear_inputs();
      return;
    end
    chk("grant_idx", 32'(bus.req_ready), 32'(1) << v.idx);
    chk("m_addr",    32'(bus.m_addr),    32'(v.addr));
    chk("m_rw",      32'(bus.m_rw),      32'(v.rw));
    chk("m_data_w",  32'(bus.m_data_w),  32'(v.wdata));
    chk("m_start",   32'(bus.m_start),   32'(1));
    bus.req_valid[v.idx] = 1'b0;

    rc = 0;
    extra = 0;
    for (int c = 2; c <= 200; c++) begin
      tick();
      if (bus.req_ready != '0) extra++;
      if (bus.rsp_valid != '0) begin
        rc = c;
        break;
      end
      if (c == 3 && v.mode != M_NOSTART) chk("start_drop", 32'(bus.m_start), 32'(0));
      if (c == 9 && v.mode == M_NOSTART) chk("start_held", 32'(bus.m_start), 32'(1));
      if (c == 5 && v.mode != M_NOSTART) chk("addr_hold", 32'(bus.m_addr), 32'(v.addr));
      if (c == 2 && v.mode != M_NOSTART) bus.m_busy = 1'b1;
      if (c == 5 && v.mode == M_ACK) begin
        bus.m_valid_out = 1'b1;
        bus.m_data_out  = v.sdata;
      end
      if (c == 5 && v.mode == M_NACK) begin
        bus.m_valid_out = 1'b1;
        bus.m_erro_addr = 1'b1;
        bus.m_data_out  = v.sdata;
      end
      if (c == 6) begin
        bus.m_valid_out = 1'b0;
        bus.m_erro_addr = 1'b0;
        bus.m_data_out  = '0;
      end
      if (c == 7 && (v.mode == M_ACK || v.mode == M_NACK)) bus.m_busy = 1'b0;
    end
    clear_inputs();
    if (rc == 0) begin
      total++;
      bad++;
      $display("FAIL rsp_wait: got=none want=rsp_valid[%0d] at cycle %0d", v.idx, v.exp_cyc);
    end else begin
      chk("rsp_idx",    32'(bus.rsp_valid),  32'(1) << v.idx);
      chk("rsp_status", 32'(bus.rsp_status), 32'(v.exp_st));
      chk("rsp_data",   32'(bus.rsp_data),   32'(v.exp_data));
      chk("rsp_cycle",  32'(rc),             32'(v.exp_cyc));
    end
    chk("dup_grant", 32'(extra), 32'(0));
    tick();
    chk("rsp_pulse", 32'(bus.rsp_valid), 32'(0));
  endtask

  initial begin
    int seen;
    //           mask     idx addr   rw    wdata  mode       sdata  st     data   cyc
    tbl[0]  = '{4'b0001, 0, 7'h10, 1'b0, 8'hA5, M_ACK,     8'hEE, 2'b00, 8'h00, 8};
    tbl[1]  = '{4'b0100, 2, 7'h59, 1'b1, 8'h00, M_ACK,     8'hB5, 2'b00, 8'hB5, 8};
    tbl[2]  = '{4'b1111, 0, 7'h20, 1'b0, 8'h30, M_ACK,     8'h11, 2'b00, 8'h00, 8};
    tbl[3]  = '{4'b1110, 1, 7'h21, 1'b0, 8'h31, M_ACK,     8'h12, 2'b00, 8'h00, 8};
    tbl[4]  = '{4'b1100, 2, 7'h22, 1'b0, 8'h32, M_ACK,     8'h13, 2'b00, 8'h00, 8};
    tbl[5]  = '{4'b1000, 3, 7'h23, 1'b0, 8'h33, M_ACK,     8'h14, 2'b00, 8'h00, 8};
    tbl[6]  = '{4'b1111, 0, 7'h20, 1'b0, 8'h30, M_ACK,     8'h15, 2'b00, 8'h00, 8};
    tbl[7]  = '{4'b0010, 1, 7'h33, 1'b1, 8'h00, M_NACK,    8'h77, 2'b01, 8'h00, 8};
    tbl[8]  = '{4'b1000, 3, 7'h44, 1'b1, 8'h00, M_NOSTART, 8'h00, 2'b10, 8'h00, 10};
    tbl[9]  = '{4'b0001, 0, 7'h55, 1'b1, 8'h00, M_STUCK,   8'h00, 2'b11, 8'h00, 104};
    tbl[10] = '{4'b0011, 1, 7'h66, 1'b1, 8'h00, M_ACK,     8'hC3, 2'b00, 8'hC3, 8};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      // Fresh arbitration pointer for the all-requesters ordering run.
      if (i == 2) do_reset();
      do_txn(tbl[i]);
    end

    // Reset asserted while a transaction is in RUN.
    bus.req_addr[2*7 +: 7] = 7'h4A;
    bus.req_data[2*8 +: 8] = 8'h5C;
    bus.req_valid = 4'b0100;
    tick();
    chk("rr_grant2", 32'(bus.req_ready), 32'(4'b0100));
    bus.req_valid = '0;
    tick();
    bus.m_busy = 1'b1;
    tick();
    chk("rr_run", 32'(bus.m_start), 32'(0));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    bus.m_busy = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.rsp_valid != '0) seen++;
    end
    chk("midrst_norsp", 32'(seen), 32'(0));
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    tick();
    chk("post_rst_grant", 32'(bus.req_ready), 32'(4'b0001));
    bus.req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=sim time limit want=finish");
    $fatal(1);
  end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Round-robin arbiter and transaction sequencer placed in front of `i2c_master`. It accepts single-byte read/write requests from up to `N_REQ` requesters and grants one at a time. For the granted request it drives the master's `addr`/`rw`/`data_w`/`start` and tracks `busy` to completion. It then returns read data and a status code to the granted requester, and has a watchdog so a hung bus cannot lock out the other requesters.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `START_WAIT`, default 8: cycles allowed between `m_start` rising and `m_busy` rising.
- `TIMEOUT_CYC`, default 65535: cycles allowed with `m_busy` high before the transaction is abandoned.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester request, level, held until `req_ready`.
- `req_addr` in N_REQ*7: packed 7-bit target addresses; requester i uses bits [7i+6:7i].
- `req_rw` in N_REQ: 1 = read, 0 = write.
- `req_data` in N_REQ*8: packed write bytes.
- `req_ready` out N_REQ: one-hot, one-cycle grant/accept pulse.
- `rsp_valid` out N_REQ: one-hot, one-cycle completion pulse to the granted requester.
- `rsp_data` out 8: read byte; 0 for writes and for errors.
- `rsp_status` out 2: 00 OK, 01 NACK, 10 NOSTART, 11 TIMEOUT.
- `m_addr` out 7, `m_rw` out 1, `m_data_w` out 8: to `i2c_master`; held stable for the whole transaction.
- `m_start` out 1: to `i2c_master`.
- `m_data_out` in 8, `m_valid_out` in 1, `m_busy` in 1, `m_erro_addr` in 1: from `i2c_master`.

## Operation
- FSM states: IDLE, ISSUE, RUN, RESP.
- **IDLE**
  - If any `req_valid` bit is set, pick the first set bit searching from `last+1` upward, modulo N_REQ.
  - Latch that requester's index, addr, rw and data.
  - Update `last` to the picked index.
  - Go to ISSUE.
- **ISSUE**
  - `req_ready[idx]` pulses in the first ISSUE cycle only.
  - `m_start` is held high while in ISSUE.
  - `m_busy` seen high: drop `m_start`, go to RUN.
  - `START_WAIT` cycles elapse without `m_busy`: status NOSTART, go to RESP.
- **RUN**
  - `m_valid_out` high: capture `m_data_out`, but only when rw = 1.
  - `m_erro_addr` high: set a sticky NACK flag.
  - `m_busy` falls: status is NACK if the flag is set, else OK. Go to RESP.
  - Counter reaches `TIMEOUT_CYC`: status TIMEOUT, go to RESP.
- **RESP**
  - Pulse `rsp_valid[idx]` with `rsp_data` and `rsp_status`.
  - Clear the flag and counters, go to IDLE.
- **Simultaneous events in RUN**
  - `m_erro_addr` together with `m_valid_out`: NACK wins and the data is discarded.
  - `m_busy` falling together with timeout expiry: the normal completion wins.
- Requesters may drop `req_valid` before their grant with no effect. Request fields are ignored after the grant.
- `req_valid` changes during ISSUE, RUN or RESP are not evaluated until the next IDLE.
- Reset value of every output is 0. `last` resets to N_REQ-1, so requester 0 wins the first arbitration.
- Reset mid-transaction aborts it with no `rsp_valid` pulse. The `i2c_master` is reset by the same `rst_n`.

## Timing
- Request held in IDLE during cycle 0:
  - cycle 1: ISSUE, with `req_ready[idx]` = 1 and `m_start` = 1.
  - `m_addr`, `m_rw` and `m_data_w` are valid from cycle 1.
- `m_busy` first sampled high in cycle k:
  - cycle k+1: RUN, `m_start` = 0.
- `m_busy` first sampled low in RUN in cycle j:
  - cycle j+1: RESP, `rsp_valid` pulse.
  - cycle j+2: IDLE.
  - earliest next grant pulse in cycle j+3.
- NOSTART: `rsp_valid` pulses `START_WAIT`+1 cycles after the grant.
- TIMEOUT: `rsp_valid` pulses `TIMEOUT_CYC`+1 cycles after entering RUN.
- Counter widths: `$clog2(START_WAIT+1)` and `$clog2(TIMEOUT_CYC+1)`. The counters saturate and never wrap.
- Round-robin pointer wraps from N_REQ-1 to 0.

## Structure
- Package `i2c_arb_pkg`:
  - state enum (IDLE/ISSUE/RUN/RESP);
  - status enum (`ST_OK`, `ST_NACK`, `ST_NOSTART`, `ST_TIMEOUT`);
  - status width constant.
- Sub-module `i2c_rr_pick`: combinational round-robin picker.
  - Inputs: `req[N_REQ]`, `last`.
  - Outputs: `grant_idx`, `any`.
- Top level contains the FSM, command latches, counters, the NACK flag and the response register.

## Test plan
- Requester 0 writes addr 0x10, data 0xA5, with a behavioral slave that ACKs:
  - required: `m_addr` = 0x10, `m_rw` = 0, `m_data_w` = 0xA5;
  - `rsp_valid[0]` with status 00 and `rsp_data` 0x00.
- Requester 2 reads addr 0x59 and the slave returns 0xB5:
  - required: `rsp_valid[2]` with `rsp_data` 0xB5 and status 00.
- All 4 requesters raise `req_valid` in the same cycle after reset:
  - required: grant order 0, 1, 2, 3;
  - then, with requests re-raised, 0 again;
  - never two grants in one transaction.
- Slave NACKs the address (`m_erro_addr` pulse during RUN, together with `m_valid_out`):
  - required: status 01, `rsp_data` 0x00.
- `m_busy` tied low:
  - required: status 10 exactly 9 cycles after the grant (`START_WAIT`=8).
- `m_busy` stuck high with `TIMEOUT_CYC`=100:
  - required: status 11 after 101 RUN cycles, then the next requester is granted.
- `rst_n` asserted in RUN:
  - required: all outputs 0 immediately, no `rsp_valid`;
  - requester 0 is granted first after release.
